mux_reduce_pipe: RTL and testbench

//  Parametrised, pipelined reduction of N words into one word with a runtime-selectable

---
 rtl/mux_reduce_pipe_if.sv | 25 ++
 rtl/mux_reduce_pipe.sv | 101 ++++++++++
 tb/tb_mux_reduce_pipe.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_reduce_pipe_if.sv
// Valid/ready bundle for mux_reduce_pipe: packed multi-word
// upstream side and single-word downstream side.
interface mux_reduce_pipe_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic           up_valid;
    logic           up_ready;
    logic [N*W-1:0] up_data;
    logic [1:0]     up_mode;
    logic           down_valid;
    logic           down_ready;
    logic [W-1:0]   down_data;
    logic [1:0]     down_mode;

    modport master (
        output up_valid, up_data, up_mode, down_ready,
        input  up_ready, down_valid, down_data, down_mode
    );

    modport slave (
        input  up_valid, up_data, up_mode, down_ready,
        output up_ready, down_valid, down_data, down_mode
    );
endinterface

// File: rtl/mux_reduce_pipe.sv
// Pipelined N-to-1 bitwise reduction (OR/AND/XOR/PASS0) built
// purely from 2:1 muxes, one register level per tree level.
module mux_reduce_pipe #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_reduce_pipe_if.slave bus
);
    localparam int STAGES = $clog2(N);
    // Level s holds N>>(s+1) words; all levels packed back to back.
    localparam int DW = (N - 1) * W;

    logic [DW-1:0]           data_q;
    logic [DW-1:0]           data_d;
    logic [2*STAGES-1:0]     mode_q;
    logic [2*STAGES-1:0]     mode_d;
    logic [STAGES-1:0]       vld_q;
    logic [STAGES-1:0]       vld_d;
    // Inputs to every level: up_* ports at the bottom, then each
    // level's registers. The top slot is the output register.
    logic [(2*N-1)*W-1:0]    src;
    logic [2*STAGES+1:0]     msrc;
    logic [STAGES:0]         vsrc;
    logic                    adv;

    function automatic logic mux2(
        input logic sel,
        input logic d0,
        input logic d1
    );
        return sel ? d1 : d0;
    endfunction

    function automatic logic [W-1:0] red2(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   m
    );
        logic [W-1:0] y;
        logic         r_or;
        logic         r_and;
        logic         nb;
        logic         r_xor;
        logic         r_p0;
        logic         lo;
        logic         hi;
        y = '0;
        for (int i = 0; i < W; i++) begin
            r_or   = mux2(a[i], b[i], 1'b1);
            r_and  = mux2(a[i], 1'b0, b[i]);
            nb     = mux2(b[i], 1'b1, 1'b0);
            r_xor  = mux2(a[i], b[i], nb);
            r_p0   = mux2(1'b0, a[i], 1'b0);
            lo     = mux2(m[0], r_or, r_and);
            hi     = mux2(m[0], r_xor, r_p0);
            y[i]   = mux2(m[1], lo, hi);
        end
        return y;
    endfunction

    assign src  = {data_q, bus.up_data};
    assign msrc = {mode_q, bus.up_mode};
    assign vsrc = {vld_q, bus.up_valid};

    assign bus.down_valid = vsrc[STAGES];
    assign bus.down_data  = src[(2*N-2)*W +: W];
    assign bus.down_mode  = msrc[2*STAGES +: 2];

    assign adv          = !bus.down_valid || bus.down_ready;
    assign bus.up_ready = adv;

    // Combine each adjacent pair of level s into slot j of level s+1.
    always_comb begin
        data_d = '0;
        mode_d = msrc[2*STAGES-1:0];
        vld_d  = vsrc[STAGES-1:0];
        for (int s = 0; s < STAGES; s++) begin
            for (int j = 0; j < (N >> (s + 1)); j++) begin
                data_d[(N - (N >> s) + j)*W +: W] = red2(
                    src[(2*N - 2*(N >> s) + 2*j)*W +: W],
                    src[(2*N - 2*(N >> s) + 2*j + 1)*W +: W],
                    msrc[2*s +: 2]);
            end
        end
    end

    // Whole pipeline shifts together on advance, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= '0;
            vld_q  <= '0;
        end else if (adv) begin
            data_q <= data_d;
            mode_q <= mode_d;
            vld_q  <= vld_d;
        end
    end
endmodule

// File: tb/tb_mux_reduce_pipe.sv
// Self-checking bench for mux_reduce_pipe: three instances
// (4x8, 2x1, 16x8) against a whole-vector reduction model.
module tb_mux_reduce_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux_reduce_pipe_if #(.N(4),  .W(8)) ia ();
    mux_reduce_pipe_if #(.N(2),  .W(1)) ib ();
    mux_reduce_pipe_if #(.N(16), .W(8)) ic ();

    mux_reduce_pipe #(.N(4),  .W(8)) ua (.clk(clk), .rst(rst), .bus(ia));
    mux_reduce_pipe #(.N(2),  .W(1)) ub (.clk(clk), .rst(rst), .bus(ib));
    mux_reduce_pipe #(.N(16), .W(8)) uc (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        int         cyc;
        int         st;
    } exp_t;

    exp_t       sbq [3][$];
    bit         hold [3];
    logic [7:0] hd [3];
    logic [1:0] hm [3];
    int         stc [3];
    int         outc [3];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reduction of all n words of width w, straight from the mode rules.
    function automatic logic [7:0] model(input logic [127:0] f,
                                         input int n, input int w,
                                         input logic [1:0] m);
        logic [7:0]   mask;
        logic [7:0]   r;
        logic [7:0]   wd;
        logic [127:0] sh;
        mask = 8'((9'd1 << w) - 9'd1);
        r    = (m == 2'd1) ? mask : 8'h00;
        for (int i = 0; i < n; i++) begin
            sh = f >> (i * w);
            wd = sh[7:0] & mask;
            case (m)
                2'd0:    r = r | wd;
                2'd1:    r = r & wd;
                2'd2:    r = r ^ wd;
                default: if (i == 0) r = wd;
            endcase
        end
        return r;
    endfunction

    task automatic sb_step(input int id, input int n, input int w,
                           input int stg, input logic upv,
                           input logic upr, input logic [127:0] upd,
                           input logic [1:0] upm, input logic dv,
                           input logic dr, input logic [7:0] dd,
                           input logic [1:0] dm);
        exp_t e;
        if (rst) begin
            sbq[id].delete();
            hold[id] = 1'b0;
            return;
        end
        chk($sformatf("up_ready_rule%0d", id), 32'(upr),
            32'(!dv || dr));
        if (hold[id]) begin
            chk($sformatf("stall_valid%0d", id), 32'(dv), 32'd1);
            chk($sformatf("stall_data%0d", id), 32'(dd), 32'(hd[id]));
            chk($sformatf("stall_mode%0d", id), 32'(dm), 32'(hm[id]));
        end
        if (dv && dr) begin
            if (sbq[id].size() == 0) begin
                chk($sformatf("unexpected_out%0d", id), 32'(dd), 32'hx);
            end else begin
                e = sbq[id].pop_front();
                outc[id]++;
                chk($sformatf("out_data%0d", id), 32'(dd), 32'(e.d));
                chk($sformatf("out_mode%0d", id), 32'(dm), 32'(e.m));
                if (e.st == stc[id])
                    chk($sformatf("latency%0d", id), 32'(cyc - e.cyc),
                        32'(stg));
            end
        end
        if (upv && upr) begin
            e.d   = model(upd, n, w, upm);
            e.m   = upm;
            e.cyc = cyc;
            e.st  = stc[id];
            sbq[id].push_back(e);
        end
        if (!dr) stc[id]++;
        hold[id] = dv && !dr;
        hd[id]   = dd;
        hm[id]   = dm;
    endtask

    // Compare every instance against the model once per cycle.
    always @(negedge clk) begin
        sb_step(0, 4, 8, 2, ia.up_valid, ia.up_ready,
                {96'b0, ia.up_data}, ia.up_mode, ia.down_valid,
                ia.down_ready, ia.down_data, ia.down_mode);
        sb_step(1, 2, 1, 1, ib.up_valid, ib.up_ready,
                {126'b0, ib.up_data}, ib.up_mode, ib.down_valid,
                ib.down_ready, {7'b0, ib.down_data}, ib.down_mode);
        sb_step(2, 16, 8, 4, ic.up_valid, ic.up_ready,
                ic.up_data, ic.up_mode, ic.down_valid,
                ic.down_ready, ic.down_data, ic.down_mode);
        cyc++;
    end

    task automatic a_push(input logic [31:0] d, input logic [1:0] m);
        bit ok;
        int n;
        ia.up_valid = 1'b1;
        ia.up_data  = d;
        ia.up_mode  = m;
        n  = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = ia.up_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic a_one(input logic [31:0] d, input logic [1:0] m,
                         input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        ia.up_valid = 1'b1;
        ia.up_data  = d;
        ia.up_mode  = m;
        chk({nm, "_rdy"}, 32'(ia.up_ready), 32'd1);
        @(posedge clk);
        #1;
        ia.up_valid = 1'b0;
        chk({nm, "_early"}, 32'(ia.down_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_dv"}, 32'(ia.down_valid), 32'd1);
        chk({nm, "_data"}, 32'(ia.down_data), 32'(e));
        chk({nm, "_mode"}, 32'(ia.down_mode), 32'(m));
    endtask

    task automatic c_one(input logic [127:0] d, input logic [1:0] m,
                         input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        ic.up_valid = 1'b1;
        ic.up_data  = d;
        ic.up_mode  = m;
        @(posedge clk);
        #1;
        ic.up_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_early"}, 32'(ic.down_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_dv"}, 32'(ic.down_valid), 32'd1);
        chk({nm, "_data"}, 32'(ic.down_data), 32'(e));
        chk({nm, "_mode"}, 32'(ic.down_mode), 32'(m));
    endtask

    task automatic b_one(input logic [1:0] d, input logic [1:0] m,
                         input logic e, input string nm);
        @(posedge clk);
        #1;
        ib.up_valid = 1'b1;
        ib.up_data  = d;
        ib.up_mode  = m;
        @(posedge clk);
        #1;
        ib.up_valid = 1'b0;
        chk({nm, "_dv"}, 32'(ib.down_valid), 32'd1);
        chk({nm, "_data"}, 32'(ib.down_data), 32'(e));
        chk({nm, "_mode"}, 32'(ib.down_mode), 32'(m));
    endtask

    int base;

    initial begin
        ia.up_valid = 1'b0; ia.up_data = '0; ia.up_mode = '0;
        ia.down_ready = 1'b1;
        ib.up_valid = 1'b0; ib.up_data = '0; ib.up_mode = '0;
        ib.down_ready = 1'b1;
        ic.up_valid = 1'b0; ic.up_data = '0; ic.up_mode = '0;
        ic.down_ready = 1'b1;
        #1;
        chk("rst_dv_a", 32'(ia.down_valid), 32'd0);
        chk("rst_data_a", 32'(ia.down_data), 32'd0);
        chk("rst_mode_a", 32'(ia.down_mode), 32'd0);
        chk("rst_rdy_a", 32'(ia.up_ready), 32'd1);
        chk("rst_dv_b", 32'(ib.down_valid), 32'd0);
        chk("rst_dv_c", 32'(ic.down_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Mode coverage on words {00,0F,F0,01}
        a_one(32'h01F00F00, 2'd0, 8'hFF, "or");
        a_one(32'h01F00F00, 2'd1, 8'h00, "and");
        a_one(32'h01F00F00, 2'd2, 8'hFE, "xor");
        a_one(32'h01F00F00, 2'd3, 8'h00, "pass0");
        a_one(32'h5A3C0FA5, 2'd3, 8'hA5, "pass0b");
        repeat (3) @(posedge clk);
        #1;

        // Streaming with rotating modes
        base = outc[0];
        for (int i = 0; i < 8; i++)
            a_push($urandom, 2'(i));
        ia.up_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stream_count", 32'(outc[0] - base), 32'd8);

        // Backpressure with the first word held at the output
        base = outc[0];
        a_push(32'h01F00F00, 2'd0);
        a_push(32'h12345678, 2'd2);
        ia.up_valid = 1'b0;
        chk("bp_dv", 32'(ia.down_valid), 32'd1);
        ia.down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_up_ready", 32'(ia.up_ready), 32'd0);
            chk("bp_hold", 32'(ia.down_data), 32'hFF);
        end
        ia.down_ready = 1'b1;
        a_push(32'hFFFFFFFF, 2'd1);
        a_push(32'h00000000, 2'd2);
        ia.up_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_count", 32'(outc[0] - base), 32'd4);

        // Reset with two words in flight
        a_push(32'hDEADBEEF, 2'd0);
        a_push(32'hCAFEF00D, 2'd2);
        ia.up_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_dv", 32'(ia.down_valid), 32'd0);
        chk("rst_mid_rdy", 32'(ia.up_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_stale", 32'(ia.down_valid), 32'd0);
        end

        // Hand-computed corner cases on the narrow and wide trees
        b_one(2'b11, 2'd2, 1'b0, "b_xor11");
        b_one(2'b10, 2'd0, 1'b1, "b_or10");
        b_one(2'b10, 2'd3, 1'b0, "b_pass10");
        c_one({16{8'hFF}}, 2'd1, 8'hFF, "c_andff");
        c_one({16{8'hA5}}, 2'd2, 8'h00, "c_xora5");
        c_one({8'h80, {15{8'h00}}}, 2'd0, 8'h80, "c_or80");

        // Random sweep with random backpressure on the 2x1 and 16x8 trees
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            ib.up_valid   = 1'($urandom_range(0, 1));
            ib.up_data    = 2'($urandom);
            ib.up_mode    = 2'($urandom);
            ib.down_ready = ($urandom_range(0, 3) != 0);
            ic.up_valid   = 1'($urandom_range(0, 1));
            ic.up_data    = {$urandom, $urandom, $urandom, $urandom};
            ic.up_mode    = 2'($urandom);
            ic.down_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        ib.up_valid = 1'b0;
        ib.down_ready = 1'b1;
        ic.up_valid = 1'b0;
        ic.down_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        chk("drain_a", 32'(sbq[0].size()), 32'd0);
        chk("drain_b", 32'(sbq[1].size()), 32'd0);
        chk("drain_c", 32'(sbq[2].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
